// File: rtl/approx_mul_sched.sv
// ---------------------------------------------------------------------------
// approx_mul_sched
//
// Shares one 8x8 approximate multiplier datapath between two requesters.
// One operand pair is granted per cycle, round-robin when both requesters
// compete. Each issued pair is tagged with its requester ID. The tag travels
// through a tag pipe that is MUL_LAT deep, so it lines up with the returning
// product. The product is then steered into that requester's result FIFO.
// Issue is credit-limited: a requester may only be granted while its FIFO
// occupancy plus its in-flight tags is below DEPTH, so a returning product
// always finds space. An enable/drain FSM stops new issue when en falls and
// reports idle once the tag pipe has emptied.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active low
//   en           in   1   1 = issue requests, 0 = stop issuing and drain
//   req_valid    in   2   per-requester operand valid
//   req_ready    out  2   one-hot grant, transfer when valid & ready
//   req_a0/b0    in   8   requester 0 operands
//   req_a1/b1    in   8   requester 1 operands
//   mul_issue    out  1   operands presented to the datapath this cycle
//   mul_a/mul_b  out  8   operands to the partial-product generator
//   mul_product  in   16  datapath result, valid MUL_LAT cycles after issue
//   rsp_valid    out  2   result FIFO i non-empty
//   rsp_ready    in   2   pop FIFO i head
//   rsp_prod0/1  out  16  FIFO heads, 0 when empty
//   idle         out  1   FSM in IDLE with nothing in flight
// ---------------------------------------------------------------------------
module approx_mul_sched #(
  parameter int MUL_LAT = 1,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_a0,
  input  logic [7:0]  req_b0,
  input  logic [7:0]  req_a1,
  input  logic [7:0]  req_b1,
  output logic        mul_issue,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_product,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_prod0,
  output logic [15:0] rsp_prod1,
  output logic        idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // The credit sum is one bit wider than the FIFO count, so it cannot wrap.
  localparam logic [CW:0] SUM_ONE = (CW+1)'(1);
  localparam logic [CW:0] SUM_LIM = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_rr;
  logic [MUL_LAT-1:0]   r_tag_vld;
  logic [MUL_LAT-1:0]   r_tag_id;

  logic [15:0]          r_mem [2][DEPTH];
  logic [PW-1:0]        r_wptr [2];
  logic [PW-1:0]        r_rptr [2];
  logic [CW-1:0]        r_cnt [2];

  logic [1:0][CW:0]     w_infl;
  logic [1:0][CW:0]     w_sum;
  logic [1:0]           w_elig;
  logic [1:0]           w_grant;
  logic                 w_pipe_empty;
  logic                 w_ret_vld;
  logic                 w_ret_id;
  logic [1:0]           w_push;
  logic [1:0]           w_pop;

  // ---- control FSM ---------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_pipe_empty = ~|r_tag_vld;

  always_comb begin
    w_state_nxt = r_state;
    idle        = 1'b0;
    case (r_state)
      S_IDLE: begin
        idle = 1'b1;
        if (en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (en)                w_state_nxt = S_RUN;
        else if (w_pipe_empty) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- credit check and arbitration ----------------------------------------
  // In-flight count includes the tag at the last stage even though its
  // product is being written this cycle; that is conservative and keeps the
  // credit check purely registered-state based.
  always_comb begin
    w_infl = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      if (r_tag_vld[k]) begin
        if (r_tag_id[k]) w_infl[1] = w_infl[1] + SUM_ONE;
        else             w_infl[0] = w_infl[0] + SUM_ONE;
      end
    end
  end

  always_comb begin
    w_sum  = '0;
    w_elig = '0;
    for (int i = 0; i < 2; i++) begin
      w_sum[i]  = {1'b0, r_cnt[i]} + w_infl[i];
      w_elig[i] = req_valid[i] & (r_state == S_RUN) & (w_sum[i] < SUM_LIM);
    end
  end

  always_comb begin
    w_grant = 2'b00;
    if (w_elig == 2'b11) w_grant = r_rr ? 2'b10 : 2'b01;
    else                 w_grant = w_elig;
  end

  assign req_ready = w_grant;
  assign mul_issue = |w_grant;

  always_comb begin
    mul_a = 8'd0;
    mul_b = 8'd0;
    if (w_grant[0]) begin
      mul_a = req_a0;
      mul_b = req_b0;
    end else if (w_grant[1]) begin
      mul_a = req_a1;
      mul_b = req_b1;
    end
  end

  // Pointer moves to the requester that was not just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr <= 1'b0;
    end else if (|w_grant) begin
      r_rr <= ~w_grant[1];
    end
  end

  // ---- tag pipe: stage 0 .. MUL_LAT-1 --------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_vld <= '0;
      r_tag_id  <= '0;
    end else begin
      r_tag_vld[0] <= |w_grant;
      r_tag_id[0]  <= w_grant[1];
      for (int k = 1; k < MUL_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
    end
  end

  assign w_ret_vld = r_tag_vld[MUL_LAT-1];
  assign w_ret_id  = r_tag_id[MUL_LAT-1];

  // ---- result FIFOs --------------------------------------------------------
  always_comb begin
    w_push = '0;
    w_pop  = '0;
    for (int i = 0; i < 2; i++) begin
      w_pop[i] = rsp_ready[i] & (r_cnt[i] != '0);
    end
    w_push[0] = w_ret_vld & ~w_ret_id;
    w_push[1] = w_ret_vld &  w_ret_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + PW'(1);
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + CW'(1);
        else if (w_pop[i] && !w_push[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
      end
    end
  end

  // Storage carries data only; emptiness is tracked by the counters, so the
  // array needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= mul_product;
    end
  end

  assign rsp_valid[0] = (r_cnt[0] != '0);
  assign rsp_valid[1] = (r_cnt[1] != '0);
  assign rsp_prod0    = rsp_valid[0] ? r_mem[0][r_rptr[0]] : 16'd0;
  assign rsp_prod1    = rsp_valid[1] ? r_mem[1][r_rptr[1]] : 16'd0;

endmodule
